// File: rtl/conbus_rr_arb_pkg.sv
// Shared constants and state encoding for the conbus round-robin arbiter.
// Optional watchdog is enabled with CONBUS_ARB_WATCHDOG_EN.
package conbus_pkg;

    localparam int CONBUS_MAX_MASTERS = 8;
    localparam int CONBUS_IDX_W       = 3;
    localparam int CONBUS_TIMEOUT_DEF = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/conbus_rr_arb_if.sv
// Request/grant bundle between the conbus masters and the arbiter.
// The arbiter takes the slave side; masters/bench drive the master side.
interface conbus_rr_arb_if
    import conbus_pkg::*;
#(
    parameter int N = 5
) ();

    logic [N-1:0]              req;
    logic                      bus_ack;
    logic [N-1:0]              gnt;
    logic                      gnt_valid;
    logic [CONBUS_IDX_W-1:0]   gnt_idx;
    logic                      wd_err;

    modport master (
        output req,
        output bus_ack,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx,
        input  wd_err
    );

    modport slave (
        input  req,
        input  bus_ack,
        output gnt,
        output gnt_valid,
        output gnt_idx,
        output wd_err
    );

endinterface

// File: rtl/conbus_rr_arb_pick.sv
// Combinational rotating-priority encoder: first candidate after last_i.
// Shared by the idle-grant and handover paths of conbus_rr_arb.
module conbus_rr_pick
    import conbus_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]            cand_i,
    input  logic [CONBUS_IDX_W-1:0] last_i,
    output logic                    found_o,
    output logic [CONBUS_IDX_W-1:0] idx_o
);

    always_comb begin
        int           p;
        logic [N-1:0] sh;
        found_o = 1'b0;
        idx_o   = '0;
        p       = int'(last_i);
        sh      = '0;
        for (int k = 0; k < N; k++) begin
            // compare-and-reset wrap keeps non power-of-two N correct
            p  = (p >= N - 1) ? 0 : p + 1;
            sh = cand_i >> p;
            if (!found_o && sh[0]) begin
                found_o = 1'b1;
                idx_o   = CONBUS_IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/conbus_rr_arb.sv
// Round-robin owner arbiter for the shared conbus Wishbone bus.
// Define CONBUS_ARB_WATCHDOG_EN to add the no-ack watchdog.
module conbus_rr_arb
    import conbus_pkg::*;
#(
    parameter int N_MASTERS = 5,
    parameter int TIMEOUT   = CONBUS_TIMEOUT_DEF,
    parameter int WD_W      = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    conbus_rr_arb_if.slave bus
);

    localparam logic [N_MASTERS-1:0] ONE =
        {{(N_MASTERS - 1){1'b0}}, 1'b1};
    localparam logic [CONBUS_IDX_W-1:0] LAST_RST =
        CONBUS_IDX_W'(N_MASTERS - 1);

    if (N_MASTERS < 2 || N_MASTERS > CONBUS_MAX_MASTERS) begin : g_bad_n
        $error("conbus_rr_arb: N_MASTERS out of range");
    end

    arb_state_e state_q, state_d;

    logic [N_MASTERS-1:0]    gnt_q, gnt_d;
    logic                    gv_q, gv_d;
    logic [CONBUS_IDX_W-1:0] idx_q, idx_d;
    logic [CONBUS_IDX_W-1:0] last_q, last_d;

    logic [N_MASTERS-1:0]    mask;
    logic [N_MASTERS-1:0]    cand;
    logic                    found;
    logic [CONBUS_IDX_W-1:0] pidx;
    logic                    own_req;
    logic                    timeout;

    assign cand    = bus.req & ~mask;
    assign own_req = |(gnt_q & bus.req);

    conbus_rr_pick #(
        .N (N_MASTERS)
    ) u_pick (
        .cand_i  (cand),
        .last_i  (last_q),
        .found_o (found),
        .idx_o   (pidx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gv_d    = gv_q;
        idx_d   = idx_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    gnt_d   = ONE << pidx;
                    gv_d    = 1'b1;
                    idx_d   = pidx;
                    last_d  = pidx;
                end
            end
            OWN: begin
                if (timeout) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    gv_d    = 1'b0;
                end else if (!own_req) begin
                    // owner released: hand over directly, no idle bubble
                    if (found) begin
                        gnt_d  = ONE << pidx;
                        idx_d  = pidx;
                        last_d = pidx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        gv_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                gv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gv_q    <= 1'b0;
            idx_q   <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gv_q    <= gv_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

`ifdef CONBUS_ARB_WATCHDOG_EN
    logic [WD_W-1:0]      cnt_q, cnt_d;
    logic [N_MASTERS-1:0] mask_q, mask_d;

    // ack in the terminal cycle wins over the timeout
    assign timeout = (state_q == OWN)
                  && (cnt_q == WD_W'(TIMEOUT - 1))
                  && !bus.bus_ack;

    assign mask       = mask_q;
    assign bus.wd_err = timeout && !sys_rst;

    always_comb begin
        cnt_d = '0;
        if (state_d == OWN && gnt_d == gnt_q && !bus.bus_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
        mask_d = (mask_q | (timeout ? gnt_q : '0)) & bus.req;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q  <= '0;
            mask_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end
`else
    logic unused_wd;

    assign timeout    = 1'b0;
    assign mask       = '0;
    assign bus.wd_err = 1'b0;
    assign unused_wd  = ^{bus.bus_ack, TIMEOUT, WD_W};
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gv_q;
    assign bus.gnt_idx   = idx_q;

endmodule

// File: tb/tb_conbus_rr_arb.sv
// Scoreboard bench for conbus_rr_arb against a queue-based reference model.
// Watchdog expectations follow CONBUS_ARB_WATCHDOG_EN (TIMEOUT=16).
module tb_conbus_rr_arb;
    import conbus_pkg::*;

    localparam int N  = 5;
    localparam int TO = 16;
`ifdef CONBUS_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conbus_rr_arb_if #(.N(N)) bus ();

    conbus_rr_arb #(
        .N_MASTERS (N),
        .TIMEOUT   (TO),
        .WD_W      (16)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         gv;
        logic [2:0]   idx;
        logic         wd;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // reference model: owner (-1 = idle), last winner, cycles owned
    int           m_own;
    int           m_last;
    int           m_idx;
    int           m_cnt;
    int           m_ten;
    logic [N-1:0] m_mask;

    function automatic int pick(input logic [N-1:0] c, input int last);
        for (int k = 1; k <= N; k++) begin
            if (c[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_own  = -1;
        m_last = N - 1;
        m_idx  = 0;
        m_cnt  = 0;
        m_ten  = 0;
        m_mask = '0;
    endtask

    task automatic m_grant(input int p);
        m_own  = p;
        m_idx  = p;
        m_last = p;
        m_cnt  = 0;
        m_ten  = 0;
    endtask

    task automatic step(input logic [N-1:0] r, input logic a,
                        input logic rs);
        obs_t         e;
        logic [N-1:0] one;
        logic [N-1:0] setm;
        bit           wd;
        int           p;
        @(posedge clk);
        #1;
        bus.req     = r;
        bus.bus_ack = a;
        rst         = rs;
        cyc++;
        one   = 1;
        wd    = WD && !rs && m_own >= 0 && m_cnt == TO - 1 && !a;
        e.gnt = (m_own >= 0) ? (one << m_own) : '0;
        e.gv  = (m_own >= 0);
        e.idx = 3'(m_idx);
        e.wd  = wd;
        exp_q.push_back(e);
        if (rs) begin
            m_reset();
            return;
        end
        setm = '0;
        if (m_own < 0) begin
            p = pick(r & ~m_mask, m_last);
            if (p >= 0) m_grant(p);
        end else if (wd) begin
            setm[m_own] = 1'b1;
            m_own = -1;
            m_cnt = 0;
        end else if (r[m_own]) begin
            m_cnt = a ? 0 : m_cnt + 1;
            m_ten++;
        end else begin
            p = pick(r & ~m_mask, m_last);
            if (p >= 0) m_grant(p);
            else begin
                m_own = -1;
                m_cnt = 0;
            end
        end
        m_mask = (m_mask | setm) & r;
    endtask

    // monitor: compare every presented output against the scoreboard
    initial begin
        obs_t e;
        obs_t o;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = {bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.wd_err};
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL outputs cyc%0d: got gnt=%b gv=%b idx=%0d wd=%b, want gnt=%b gv=%b idx=%0d wd=%b",
                             cyc, o.gnt, o.gv, o.idx, o.wd,
                             e.gnt, e.gv, e.idx, e.wd);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic         a;
        rst         = 1'b1;
        bus.req     = '1;
        bus.bus_ack = 1'b0;
        m_reset();

        // reset held with all requesting, then release
        step(5'b11111, 1'b0, 1'b1);
        step(5'b11111, 1'b0, 1'b1);
        step(5'b11111, 1'b0, 1'b0);
        step(5'b11111, 1'b0, 1'b0);
        step(5'b11111, 1'b0, 1'b0);
        repeat (3) step(5'b00000, 1'b0, 1'b0);

        // single master, 20-cycle tenure
        repeat (21) step(5'b00100, 1'b1, 1'b0);
        repeat (3) step(5'b00000, 1'b0, 1'b0);

        // round robin: owner drops in its second grant cycle
        repeat (14) begin
            r = 5'b10011;
            if (m_own >= 0 && m_ten == 1) r[m_own] = 1'b0;
            step(r, 1'b1, 1'b0);
        end
        repeat (3) step(5'b00000, 1'b0, 1'b0);

        // handover: master 1 waits for master 3 to release
        repeat (3) step(5'b01000, 1'b1, 1'b0);
        repeat (5) step(5'b01010, 1'b1, 1'b0);
        repeat (3) step(5'b00010, 1'b1, 1'b0);
        repeat (2) step(5'b00000, 1'b0, 1'b0);

        // reset mid-tenure
        repeat (3) step(5'b00100, 1'b1, 1'b0);
        step(5'b00100, 1'b1, 1'b1);
        repeat (3) step(5'b00100, 1'b1, 1'b0);
        repeat (2) step(5'b00000, 1'b0, 1'b0);

        // no ack: master 0 times out, masked, then re-eligible
        step(5'b00001, 1'b0, 1'b0);
        repeat (20) step(5'b00101, 1'b0, 1'b0);
        repeat (4) step(5'b00101, 1'b1, 1'b0);
        repeat (3) step(5'b00001, 1'b1, 1'b0);
        step(5'b00000, 1'b1, 1'b0);
        repeat (4) step(5'b00001, 1'b1, 1'b0);
        repeat (2) step(5'b00000, 1'b0, 1'b0);

        // ack exactly in grant cycle 16
        repeat (25) begin
            a = (m_own >= 0 && m_ten == TO - 1);
            step(5'b00010, a, 1'b0);
        end
        repeat (2) step(5'b00000, 1'b0, 1'b0);

        // long tenure without any ack
        repeat (2000) step(5'b00001, 1'b0, 1'b0);
        repeat (2) step(5'b00000, 1'b0, 1'b0);

        // random traffic
        r = '0;
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            end
            step(r, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 599) == 0));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
